ls_unit: RTL

- Load/store execution stage directly downstream of the load/store buffer.
- Accepts one issued memory instruction at a time with operands already resolved, computes the effective address and runs one request/done transaction with the memory controller.
- Loads: extends the returned data, broadcasts it on the LS result bus and writes the register file.
- Every instruction, load or store, is retired to the buffer with a one-cycle LSdone pulse.

---
 rtl/ls_pkg.sv | 50 +++++
 rtl/ls_load_ext.sv | 21 ++
 rtl/ls_unit.sv | 123 ++++++++++++
 3 files changed

// File: rtl/ls_pkg.sv
// Shared constants, opcode decode helpers and state encoding for the load/store unit.
package ls_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned TAG_W  = 4;
    localparam int unsigned NAME_W = 5;
    localparam int unsigned OP_W   = 6;

    localparam logic [OP_W-1:0] OP_NOP = OP_W'(0);
    localparam logic [OP_W-1:0] OP_LB  = OP_W'(1);
    localparam logic [OP_W-1:0] OP_LH  = OP_W'(2);
    localparam logic [OP_W-1:0] OP_LW  = OP_W'(3);
    localparam logic [OP_W-1:0] OP_LBU = OP_W'(4);
    localparam logic [OP_W-1:0] OP_LHU = OP_W'(5);
    localparam logic [OP_W-1:0] OP_SB  = OP_W'(6);
    localparam logic [OP_W-1:0] OP_SH  = OP_W'(7);
    localparam logic [OP_W-1:0] OP_SW  = OP_W'(8);

    localparam logic [1:0] MEM_BYTE = 2'd0;
    localparam logic [1:0] MEM_HALF = 2'd1;
    localparam logic [1:0] MEM_WORD = 2'd2;

    localparam logic [TAG_W-1:0]  TAG_FREE  = '1;
    localparam logic [NAME_W-1:0] NAME_FREE = '0;
    localparam logic [DATA_W-1:0] DATA_FREE = '0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } ls_state_e;

    function automatic logic is_load(input logic [OP_W-1:0] op);
        return (op == OP_LB) || (op == OP_LH) || (op == OP_LW) ||
               (op == OP_LBU) || (op == OP_LHU);
    endfunction

    function automatic logic is_store(input logic [OP_W-1:0] op);
        return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    endfunction

    function automatic logic [1:0] mem_size(input logic [OP_W-1:0] op);
        logic [1:0] sz;
        sz = MEM_WORD;
        if (op == OP_LB || op == OP_LBU || op == OP_SB) sz = MEM_BYTE;
        if (op == OP_LH || op == OP_LHU || op == OP_SH) sz = MEM_HALF;
        return sz;
    endfunction

endpackage

// File: rtl/ls_load_ext.sv
// Sign/zero extension of returned load data according to the load opcode.
module ls_load_ext
    import ls_pkg::*;
(
    input  logic [OP_W-1:0]   op_i,
    input  logic [DATA_W-1:0] rdata_i,
    output logic [DATA_W-1:0] result_o
);

    always_comb begin
        result_o = rdata_i;
        case (op_i)
            OP_LB:   result_o = {{(DATA_W-8){rdata_i[7]}}, rdata_i[7:0]};
            OP_LBU:  result_o = {{(DATA_W-8){1'b0}}, rdata_i[7:0]};
            OP_LH:   result_o = {{(DATA_W-16){rdata_i[15]}}, rdata_i[15:0]};
            OP_LHU:  result_o = {{(DATA_W-16){1'b0}}, rdata_i[15:0]};
            default: result_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/ls_unit.sv
// Load/store execution stage: address generation, one memory transaction per
// instruction, load result broadcast and a retire pulse back to the buffer.
module ls_unit
    import ls_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              LSworkEn,
    input  logic [DATA_W-1:0] operandO,
    input  logic [DATA_W-1:0] operandT,
    input  logic [DATA_W-1:0] imm,
    input  logic [TAG_W-1:0]  wrtTag,
    input  logic [NAME_W-1:0] wrtName,
    input  logic [OP_W-1:0]   opCode,
    output logic              LSreadEn,
    output logic              LSdone,
    output logic              enLSwrt,
    output logic [TAG_W-1:0]  LStag,
    output logic [DATA_W-1:0] LSdata,
    output logic              rfWrtEn,
    output logic [NAME_W-1:0] rfWrtName,
    output logic              memReq,
    output logic              memWe,
    output logic [DATA_W-1:0] memAddr,
    output logic [1:0]        memSize,
    output logic [DATA_W-1:0] memWdata,
    input  logic              memDone,
    input  logic [DATA_W-1:0] memRdata
);

    ls_state_e         state_q;
    logic [TAG_W-1:0]  tag_q;
    logic [NAME_W-1:0] name_q;
    logic [OP_W-1:0]   op_q;
    logic              ls_done_q, en_wrt_q, rf_we_q, mem_req_q, mem_we_q;
    logic [TAG_W-1:0]  ls_tag_q;
    logic [DATA_W-1:0] ls_data_q, mem_addr_q, mem_wdata_q;
    logic [NAME_W-1:0] rf_name_q;
    logic [1:0]        mem_size_q;
    logic [DATA_W-1:0] ext_data;

    ls_load_ext u_ext (
        .op_i     (op_q),
        .rdata_i  (memRdata),
        .result_o (ext_data)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            tag_q       <= TAG_FREE;
            name_q      <= NAME_FREE;
            op_q        <= OP_NOP;
            ls_done_q   <= 1'b0;
            en_wrt_q    <= 1'b0;
            rf_we_q     <= 1'b0;
            ls_tag_q    <= TAG_FREE;
            ls_data_q   <= DATA_FREE;
            rf_name_q   <= NAME_FREE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= DATA_FREE;
            mem_size_q  <= MEM_BYTE;
            mem_wdata_q <= DATA_FREE;
        end else begin
            // Result and retire strobes live for exactly one cycle.
            ls_done_q <= 1'b0;
            en_wrt_q  <= 1'b0;
            rf_we_q   <= 1'b0;
            ls_tag_q  <= TAG_FREE;
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    state_q <= ST_IDLE;
                    if (LSworkEn) begin
                        if (is_load(opCode) || is_store(opCode)) begin
                            tag_q       <= wrtTag;
                            name_q      <= wrtName;
                            op_q        <= opCode;
                            mem_addr_q  <= operandO + imm;
                            mem_wdata_q <= operandT;
                            mem_we_q    <= is_store(opCode);
                            mem_size_q  <= mem_size(opCode);
                            mem_req_q   <= 1'b1;
                            state_q     <= ST_WAIT;
                        end else begin
                            ls_done_q <= 1'b1;
                            state_q   <= ST_DONE;
                        end
                    end
                end
                ST_WAIT: begin
                    if (memDone) begin
                        mem_req_q <= 1'b0;
                        ls_done_q <= 1'b1;
                        state_q   <= ST_DONE;
                        if (is_load(op_q)) begin
                            en_wrt_q  <= 1'b1;
                            rf_we_q   <= (name_q != NAME_FREE);
                            ls_tag_q  <= tag_q;
                            ls_data_q <= ext_data;
                            rf_name_q <= name_q;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign LSreadEn  = ((state_q == ST_IDLE) || (state_q == ST_DONE)) && !LSworkEn;
    assign LSdone    = ls_done_q;
    assign enLSwrt   = en_wrt_q;
    assign LStag     = ls_tag_q;
    assign LSdata    = ls_data_q;
    assign rfWrtEn   = rf_we_q;
    assign rfWrtName = rf_name_q;
    assign memReq    = mem_req_q;
    assign memWe     = mem_we_q;
    assign memAddr   = mem_addr_q;
    assign memSize   = mem_size_q;
    assign memWdata  = mem_wdata_q;

endmodule
